string_match_sequencer: RTL and testbench

STRING_MATCH_SEQUENCER -- requirements
Module: string_match_sequencer

---
 rtl/sniffer_ctrl_pkg.sv | 8 +
 rtl/string_match_sequencer_sat_counter.sv | 14 +
 rtl/string_match_sequencer.sv | 97 +++++++++
 tb/tb_string_match_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sniffer_ctrl_pkg.sv
// sniffer_ctrl_pkg: shared types and sizes for the string match sequencer
package sniffer_ctrl_pkg;
  localparam int MAX_STRLEN = 17;
  localparam int WORD_W = 32;
  localparam int COUNT_W = 8;
  typedef logic [0:MAX_STRLEN-1][7:0] flagged_string_t;
  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, CLEAR, REPORT} state_t;
endpackage

// File: rtl/string_match_sequencer_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  // count up on inc, hold at all-ones, clear on rst or clr
  always_ff @(posedge clk)
    q <= (rst || clr) ? '0 : (inc && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/string_match_sequencer.sv
// string_match_sequencer: streams packet words into an external string comparator and reports per-packet results; define STRING_MATCH_COUNT_EN to build the match-cycle counter
module string_match_sequencer
  import sniffer_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 5,
  parameter int WORD_CNT_W = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  in_ready,
  input  logic                  cfg_we,
  input  flagged_string_t       cfg_string,
  input  logic [4:0]            cfg_strlen,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  output logic [WORD_W-1:0]     cmp_data_in,
  output flagged_string_t       cmp_flagged_string,
  output logic [4:0]            cmp_strlen,
  output logic                  cmp_clear,
  input  logic                  cmp_match,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_match,
  output logic                  res_err,
  output logic [COUNT_W-1:0]    res_count,
  output logic [WORD_CNT_W-1:0] res_words
);
  localparam int FW = $clog2(PIPE_DEPTH + 1);
  state_t state, state_n;
  logic [FW-1:0] flush_cnt;
  logic pkt_word, match_en, done, cfg_ok, match_flag, err_flag;
  assign pkt_word = in_valid && in_ready && (state == STREAM || in_sop);
  assign match_en = cmp_match && (state == STREAM || state == FLUSH || state == CLEAR);
  assign done = state == REPORT && res_ready;
  assign cfg_ok = cfg_we && cfg_ready;
  assign res_match = match_flag && cmp_strlen != 5'd0;
  assign res_err = err_flag;
  // handshake outputs forced low while rst is held; next-state selection
  always_comb begin
    state_n = state;
    in_ready = !rst && (state == IDLE || state == STREAM);
    cfg_ready = !rst && state == IDLE;
    cmp_clear = !rst && state == CLEAR;
    res_valid = !rst && state == REPORT;
    case (state)
      IDLE:    state_n = (in_valid && in_sop) ? (in_eop ? FLUSH : STREAM) : IDLE;
      STREAM:  state_n = (!in_valid || in_eop) ? FLUSH : STREAM;
      FLUSH:   state_n = (flush_cnt == FW'(PIPE_DEPTH - 1)) ? CLEAR : FLUSH;
      CLEAR:   state_n = REPORT;
      REPORT:  state_n = res_ready ? IDLE : REPORT;
      default: state_n = IDLE;
    endcase
  end
  // state register and flush timer
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    flush_cnt <= (rst || state != FLUSH) ? '0 : flush_cnt + 1'b1;
  end
  // comparator data lags accepted packet words by one cycle, zero otherwise
  always_ff @(posedge clk)
    cmp_data_in <= (!rst && pkt_word) ? in_data : '0;
  // sticky per-packet flags; a gap in STREAM starves the shifting comparator
  always_ff @(posedge clk) begin
    err_flag <= (rst || done) ? 1'b0 : (state == STREAM && !in_valid) ? 1'b1 : err_flag;
    match_flag <= (rst || done) ? 1'b0 : match_en ? 1'b1 : match_flag;
  end
  // pattern load only in IDLE; oversize lengths keep the old pattern and flag an error
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_flagged_string <= '0;
      cmp_strlen <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_ok && cfg_strlen > 5'(MAX_STRLEN);
      if (cfg_ok && cfg_strlen <= 5'(MAX_STRLEN)) begin
        cmp_flagged_string <= cfg_string;
        cmp_strlen <= cfg_strlen;
      end
    end
  end
  sat_counter #(.W(WORD_CNT_W)) u_words (
    .clk(clk), .rst(rst), .clr(done), .inc(pkt_word), .q(res_words)
  );
`ifdef STRING_MATCH_COUNT_EN
  logic [COUNT_W-1:0] match_cnt;
  sat_counter #(.W(COUNT_W)) u_matches (
    .clk(clk), .rst(rst), .clr(done), .inc(match_en), .q(match_cnt)
  );
  assign res_count = (cmp_strlen == 5'd0) ? '0 : match_cnt;
`else
  assign res_count = '0;
`endif
endmodule

// File: tb/tb_string_match_sequencer.sv
// tb_string_match_sequencer: directed checks of the string match sequencer with a behavioural comparator
module tb_string_match_sequencer;
  import sniffer_ctrl_pkg::*;
  localparam int PD = 5;
  localparam int WW = 11;
  logic clk = 0, rst = 1;
  logic [31:0] in_data = '0;
  logic in_valid = 0, in_sop = 0, in_eop = 0, in_ready;
  logic cfg_we = 0, cfg_ready, cfg_err;
  flagged_string_t cfg_string = '0;
  logic [4:0] cfg_strlen = '0;
  logic [31:0] cmp_data_in;
  flagged_string_t cmp_flagged_string;
  logic [4:0] cmp_strlen;
  logic cmp_clear, cmp_match, res_valid, res_ready = 0, res_match, res_err;
  logic [7:0] res_count;
  logic [WW-1:0] res_words;
  logic [191:0] hist = '0;
  logic model_match = 0, force_match = 0;
  int n_chk = 0, n_fail = 0;
  byte unsigned pkt[1200];

  always #5 clk = ~clk;

  string_match_sequencer #(.PIPE_DEPTH(PD), .WORD_CNT_W(WW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(in_ready), .cfg_we(cfg_we), .cfg_string(cfg_string),
    .cfg_strlen(cfg_strlen), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
    .cmp_data_in(cmp_data_in), .cmp_flagged_string(cmp_flagged_string),
    .cmp_strlen(cmp_strlen), .cmp_clear(cmp_clear), .cmp_match(cmp_match),
    .res_valid(res_valid), .res_ready(res_ready), .res_match(res_match),
    .res_err(res_err), .res_count(res_count), .res_words(res_words)
  );

  // external comparator stand-in: byte history, match when the pattern ends in the newest word
  always @(posedge clk) begin
    logic [191:0] h, m, p;
    logic f;
    h = {hist[159:0], cmp_data_in};
    m = (192'd1 << (8 * cmp_strlen)) - 192'd1;
    p = {56'd0, cmp_flagged_string};
    f = 0;
    for (int k = 0; k < 4; k++)
      if (cmp_strlen != 0 && ((h >> (8 * k)) & m) == (p & m)) f = 1;
    hist <= cmp_clear ? '0 : h;
    model_match <= f;
  end
  assign cmp_match = model_match | force_match;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int w);
    return {pkt[4*w], pkt[4*w+1], pkt[4*w+2], pkt[4*w+3]};
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_cfg_ready"}, cfg_ready, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_cmp_data_in"}, cmp_data_in, 0);
    chk({tag, "_cmp_string"}, cmp_flagged_string, 0);
    chk({tag, "_cmp_strlen"}, cmp_strlen, 0);
    chk({tag, "_cmp_clear"}, cmp_clear, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_match"}, res_match, 0);
    chk({tag, "_res_err"}, res_err, 0);
    chk({tag, "_res_count"}, res_count, 0);
    chk({tag, "_res_words"}, res_words, 0);
  endtask

  task automatic load_cfg(input logic [4:0] len, input flagged_string_t s);
    cfg_we = 1; cfg_strlen = len; cfg_string = s;
    @(negedge clk);
    cfg_we = 0;
  endtask

  // drives n words (or stops at a gap); pulses cfg_we with the current cfg_* at word cfg_at
  task automatic send_pkt(input int n, input int gap_at, input int cfg_at);
    int nw;
    nw = (gap_at >= 0) ? gap_at : n;
    for (int w = 0; w < nw; w++) begin
      if (cfg_at >= 0 && w == cfg_at + 1) chk("cfg_err_quiet", cfg_err, 0);
      in_valid = 1; in_sop = (w == 0); in_eop = (gap_at < 0 && w == n - 1);
      in_data = word(w); cfg_we = (w == cfg_at);
      @(negedge clk);
    end
    cfg_we = 0; in_sop = 0; in_eop = 0; in_data = '0;
    if (gap_at >= 0) begin
      in_valid = 0;
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  // entered in the first flush cycle; checks flush/clear timing, the result and the handshake
  task automatic finish_pkt(input logic em, input logic ee, input int ew, input int ec, input int hold);
    int k, first, nclr;
    logic [159:0] snap;
    k = 1; first = 0; nclr = 0;
    while (!res_valid && k < 40) begin
      if (cmp_clear) begin
        nclr++;
        if (first == 0) first = k;
      end
      @(negedge clk);
      k++;
    end
    chk("report_reached", res_valid, 1);
    chk("clear_cycle", first, PD + 1);
    chk("clear_pulses", nclr, 1);
    chk("res_match", res_match, em);
    chk("res_err", res_err, ee);
    chk("res_words", res_words, ew);
`ifdef STRING_MATCH_COUNT_EN
    if (ec < 0) chk("res_count_min", res_count >= 8'd1, 1);
    else chk("res_count", res_count, ec);
`else
    chk("res_count", res_count, 0);
`endif
    snap = {res_valid, res_match, res_err, res_count, res_words};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("report_stable", {res_valid, res_match, res_err, res_count, res_words}, snap);
      chk("report_in_ready", in_ready, 0);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("idle_res_valid", res_valid, 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_words_clr", {res_match, res_err, res_words}, 0);
  endtask

  typedef struct {
    logic we;
    logic [4:0] len;
    flagged_string_t str;
    logic exp_err;
    logic [4:0] exp_len;
    flagged_string_t exp_str;
  } cfg_vec_t;
  cfg_vec_t cv[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string hdr;
    int nc;
    hdr = "GET /index.html HTTP/1.1\r\nHost: www.purdue.edu\r\nUser-Agent: tb\r\n\r\n";
    for (int i = 0; i < 1200; i++) pkt[i] = (i < hdr.len()) ? hdr[i] : 8'h78;
    cv[0] = '{1, 14, "www.purdue.edu", 0, 14, "www.purdue.edu"};
    cv[1] = '{1, 20, "zzzz", 1, 14, "www.purdue.edu"};
    cv[2] = '{1, 17, "abcdefghijklmnopq", 0, 17, "abcdefghijklmnopq"};
    cv[3] = '{0, 5, "hello", 0, 17, "abcdefghijklmnopq"};
    cv[4] = '{1, 31, "bad", 1, 17, "abcdefghijklmnopq"};
    cv[5] = '{1, 0, '0, 0, 0, '0};
    cv[6] = '{1, 14, "www.google.com", 0, 14, "www.google.com"};

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_cfg_ready", cfg_ready, 1);

    for (int i = 0; i < 7; i++) begin
      cfg_we = cv[i].we; cfg_strlen = cv[i].len; cfg_string = cv[i].str;
      @(negedge clk);
      cfg_we = 0;
      chk($sformatf("cfg%0d_err", i), cfg_err, cv[i].exp_err);
      chk($sformatf("cfg%0d_len", i), cmp_strlen, cv[i].exp_len);
      chk($sformatf("cfg%0d_str", i), cmp_flagged_string, cv[i].exp_str);
      @(negedge clk);
      chk($sformatf("cfg%0d_err_end", i), cfg_err, 0);
    end

    in_valid = 1; in_sop = 0; in_data = 32'hdeadbeef;
    @(negedge clk);
    in_valid = 0;
    chk("drop_no_sop_data", cmp_data_in, 0);
    chk("drop_no_sop_idle", in_ready, 1);
    chk("drop_no_sop_words", res_words, 0);

    send_pkt(300, -1, -1);
    finish_pkt(0, 0, 300, 0, 0);

    cfg_string = "www.purdue.edu"; cfg_strlen = 14;
    send_pkt(300, -1, 0);
    chk("sop_cfg_len", cmp_strlen, 14);
    finish_pkt(1, 0, 300, -1, 0);

    cfg_string = "www.google.com"; cfg_strlen = 3;
    send_pkt(300, -1, 100);
    chk("stream_cfg_ignored", cmp_strlen, 14);
    finish_pkt(1, 0, 300, -1, 0);

    send_pkt(20, 10, -1);
    finish_pkt(0, 1, 10, 0, 0);

    send_pkt(4, -1, -1);
    finish_pkt(0, 0, 4, 0, 8);

    load_cfg(0, '0);
    force_match = 1;
    send_pkt(4, -1, -1);
    finish_pkt(0, 0, 4, 0, 0);
    force_match = 0;

    load_cfg(14, "www.purdue.edu");
    force_match = 1;
    send_pkt(300, -1, -1);
    finish_pkt(1, 0, 300, 255, 0);
    force_match = 0;

    for (int w = 0; w < 50; w++) begin
      in_valid = 1; in_sop = (w == 0); in_eop = 0; in_data = word(w);
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    chk_zero("rst_mid");
    rst = 0; in_valid = 0; in_sop = 0; in_data = '0;
    nc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cmp_clear || res_valid) nc++;
    end
    chk("rst_no_clear", nc, 0);
    load_cfg(14, "www.purdue.edu");
    send_pkt(300, -1, -1);
    finish_pkt(1, 0, 300, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
